// File: rtl/prog_loader_pkg.sv
// ---------------------------------------------------------------------------
// prog_loader_pkg
//   Shared types and constants for the boot-time program loader.
//   - state_e        : loader FSM states
//   - BYTES_PER_WORD : payload bytes assembled into one RAM word
//   - HDR_BYTES      : bytes in the word-count header (little-endian)
//   - WORD_W         : RAM data width derived from BYTES_PER_WORD
//   - BYTE_CNT_W     : width of the byte-within-word counter
// ---------------------------------------------------------------------------
package prog_loader_pkg;

    typedef enum logic [2:0] {
        ST_HDR0 = 3'd0,   // waiting for word-count low byte
        ST_HDR1 = 3'd1,   // waiting for word-count high byte
        ST_DATA = 3'd2,   // receiving payload bytes
        ST_RUN  = 3'd3,   // CPU owns the RAM port
        ST_ERR  = 3'd4    // header rejected; only rst leaves this state
    } state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int HDR_BYTES      = 2;
    localparam int WORD_W         = 8 * BYTES_PER_WORD;
    localparam int HDR_W          = 8 * HDR_BYTES;
    localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

    // True when a header word count exceeds the RAM depth of 2**size words.
    // N equal to the depth is legal (fills the RAM exactly, no wrap).
    function automatic logic count_too_big(input logic [HDR_W-1:0] n,
                                           input int unsigned      size);
        logic [32:0] depth;
        depth = 33'd1 << size;
        return (33'(n) > depth);
    endfunction

endpackage

// File: rtl/prog_loader_asm.sv
// ---------------------------------------------------------------------------
// byte_to_word_asm
//   Little-endian byte-to-word assembler. Byte k of each word (k counted
//   from 0 by a wrapping counter) lands in bits [8k+7:8k].
//
//   The first BYTES_PER_WORD-1 bytes are captured in per-lane registers.
//   The final byte is not stored: word_o presents it straight from byte_i
//   so the completed word and word_valid_o are available combinationally
//   in the same cycle the last byte is accepted. The caller registers the
//   word into its own holding register, which frees the lanes to start
//   collecting the next word on the very next edge.
//
// Ports
//   clk, rst      : clock, synchronous active-high reset (clears counter
//                   and lanes, discarding any partial word)
//   byte_valid_i  : a byte is consumed on this edge
//   byte_i        : byte data
//   word_valid_o  : combinational; high when byte_i completes a word
//   word_o        : combinational assembled word (valid with word_valid_o)
// ---------------------------------------------------------------------------
module byte_to_word_asm
    import prog_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_i,
    output logic              word_valid_o,
    output logic [WORD_W-1:0] word_o
);

    localparam logic [BYTE_CNT_W-1:0] LAST_IDX = BYTE_CNT_W'(BYTES_PER_WORD - 1);

    logic [BYTE_CNT_W-1:0] cnt_q;
    logic [BYTE_CNT_W-1:0] cnt_d;
    logic [7:0]            lane_q [BYTES_PER_WORD-1];

    // Counter wraps naturally from LAST_IDX back to 0.
    always_comb begin
        cnt_d = cnt_q;
        if (byte_valid_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // One capture register per stored byte lane.
    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_WORD - 1; gi++) begin : g_lane
            always_ff @(posedge clk) begin
                if (rst) begin
                    lane_q[gi] <= '0;
                end else if (byte_valid_i && (cnt_q == BYTE_CNT_W'(gi))) begin
                    lane_q[gi] <= byte_i;
                end
            end
            assign word_o[8*gi +: 8] = lane_q[gi];
        end
    endgenerate

    assign word_o[8*(BYTES_PER_WORD-1) +: 8] = byte_i;
    assign word_valid_o = byte_valid_i && (cnt_q == LAST_IDX);

endmodule

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
//   Boot-time program loader sitting between a byte stream and the single
//   port RAM shared with the CPU. The stream starts with a 16-bit word count
//   N (low byte first) followed by 4*N little-endian payload bytes, written
//   to RAM words 0..N-1. While loading, the loader owns the RAM port and
//   holds the CPU in reset; afterwards it passes the port through to the
//   CPU combinationally and releases cpu_rst.
//
// Parameters
//   SIZE : RAM address width (2**SIZE words)
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   ld_valid/ld_data/ld_ready : byte-stream handshake (transfer on
//                     ld_valid & ld_ready at a rising edge)
//   load_req        : one-cycle reload request, honoured only in RUN
//   cpu_rst         : registered reset to the CPU
//   cpu_wrEn/cpu_addr/cpu_wdata/cpu_rdata : CPU side of the RAM port
//   ram_wrEn/ram_addr/ram_wdata/ram_rdata : RAM side (sync read)
//   busy            : loader is in HDR0, HDR1 or DATA
//   error           : header word count exceeded the RAM depth
// ---------------------------------------------------------------------------
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int SIZE = 14
) (
    input  logic              clk,
    input  logic              rst,
    // byte stream
    input  logic              ld_valid,
    input  logic [7:0]        ld_data,
    output logic              ld_ready,
    // control / status
    input  logic              load_req,
    output logic              cpu_rst,
    output logic              busy,
    output logic              error,
    // CPU side
    input  logic              cpu_wrEn,
    input  logic [SIZE-1:0]   cpu_addr,
    input  logic [WORD_W-1:0] cpu_wdata,
    output logic [WORD_W-1:0] cpu_rdata,
    // RAM side
    output logic              ram_wrEn,
    output logic [SIZE-1:0]   ram_addr,
    output logic [WORD_W-1:0] ram_wdata,
    input  logic [WORD_W-1:0] ram_rdata
);

    // -----------------------------------------------------------------------
    // State and registers
    // -----------------------------------------------------------------------
    state_e            state_q,    state_d;
    logic [7:0]        n_lo_q,     n_lo_d;
    logic [SIZE-1:0]   word_idx_q, word_idx_d;
    logic [SIZE:0]     remain_q,   remain_d;   // words still to receive
    logic              drain_q,    drain_d;    // final word's write cycle
    logic              cpu_rst_q,  cpu_rst_d;

    // Write holding register: drives the RAM during loader ownership.
    logic              wr_en_q,    wr_en_d;
    logic [SIZE-1:0]   wr_addr_q,  wr_addr_d;
    logic [WORD_W-1:0] wr_data_q,  wr_data_d;

    logic              accept;
    logic              asm_byte_valid;
    logic              asm_word_valid;
    logic [WORD_W-1:0] asm_word;
    logic [HDR_W-1:0]  hdr_n;
    logic              cpu_owns_ram;

    // -----------------------------------------------------------------------
    // Byte-stream handshake
    // -----------------------------------------------------------------------
    // During the drain cycle the final word is being written; holding off
    // the stream there keeps stray bytes from being taken for a next load.
    always_comb begin
        ld_ready = 1'b0;
        case (state_q)
            ST_HDR0, ST_HDR1: ld_ready = 1'b1;
            ST_DATA:          ld_ready = !drain_q;
            default:          ld_ready = 1'b0;
        endcase
    end

    assign accept         = ld_valid && ld_ready;
    assign asm_byte_valid = accept && (state_q == ST_DATA);
    assign hdr_n          = {ld_data, n_lo_q};

    byte_to_word_asm u_asm (
        .clk          (clk),
        .rst          (rst),
        .byte_valid_i (asm_byte_valid),
        .byte_i       (ld_data),
        .word_valid_o (asm_word_valid),
        .word_o       (asm_word)
    );

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        n_lo_d     = n_lo_q;
        word_idx_d = word_idx_q;
        remain_d   = remain_q;
        drain_d    = drain_q;
        wr_en_d    = 1'b0;           // write strobe is a single-cycle pulse
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        case (state_q)
            ST_HDR0: begin
                if (accept) begin
                    n_lo_d  = ld_data;
                    state_d = ST_HDR1;
                end
            end

            ST_HDR1: begin
                if (accept) begin
                    word_idx_d = '0;
                    // Truncation only matters for rejected counts, which
                    // never reach DATA.
                    remain_d   = (SIZE+1)'(hdr_n);
                    if (hdr_n == '0) begin
                        state_d = ST_RUN;
                    end else if (count_too_big(hdr_n, SIZE)) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end

            ST_DATA: begin
                if (drain_q) begin
                    drain_d = 1'b0;
                    state_d = ST_RUN;
                end else if (asm_word_valid) begin
                    wr_en_d    = 1'b1;
                    wr_addr_d  = word_idx_q;
                    wr_data_d  = asm_word;
                    // Index wraps to 0 after the last word of a full-depth
                    // load; it is not used again before the next header.
                    word_idx_d = word_idx_q + 1'b1;
                    remain_d   = remain_q - 1'b1;
                    if (remain_q == (SIZE+1)'(1)) begin
                        drain_d = 1'b1;
                    end
                end
            end

            ST_RUN: begin
                if (load_req) begin
                    state_d = ST_HDR0;
                end
            end

            ST_ERR: begin
                state_d = ST_ERR;
            end

            default: begin
                state_d = ST_HDR0;
            end
        endcase

        // The CPU runs exactly when the loader will be in RUN next cycle.
        cpu_rst_d = (state_d != ST_RUN);
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_HDR0;
            n_lo_q     <= '0;
            word_idx_q <= '0;
            remain_q   <= '0;
            drain_q    <= 1'b0;
            cpu_rst_q  <= 1'b1;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            n_lo_q     <= n_lo_d;
            word_idx_q <= word_idx_d;
            remain_q   <= remain_d;
            drain_q    <= drain_d;
            cpu_rst_q  <= cpu_rst_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs and RAM port mux
    // -----------------------------------------------------------------------
    // A reload request takes the port away in the same cycle, so a CPU
    // write coinciding with load_req never reaches the RAM.
    assign cpu_owns_ram = (state_q == ST_RUN) && !load_req;

    assign ram_wrEn  = cpu_owns_ram ? cpu_wrEn  : wr_en_q;
    assign ram_addr  = cpu_owns_ram ? cpu_addr  : wr_addr_q;
    assign ram_wdata = cpu_owns_ram ? cpu_wdata : wr_data_q;
    assign cpu_rdata = ram_rdata;

    assign cpu_rst = cpu_rst_q;
    assign busy    = (state_q == ST_HDR0) || (state_q == ST_HDR1) || (state_q == ST_DATA);
    assign error   = (state_q == ST_ERR);

endmodule

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader
//   Directed bench for prog_loader (SIZE=14). A behavioural sync-read RAM is
//   attached to the RAM port; every RAM write is also logged so write
//   counts, addresses and data can be checked against hand-computed values.
// ---------------------------------------------------------------------------
module tb_prog_loader;

    localparam int SIZE = 14;

    logic              clk;
    logic              rst;
    logic              ld_valid;
    logic [7:0]        ld_data;
    logic              ld_ready;
    logic              load_req;
    logic              cpu_rst;
    logic              busy;
    logic              error;
    logic              cpu_wrEn;
    logic [SIZE-1:0]   cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              ram_wrEn;
    logic [SIZE-1:0]   ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0]     mem [0:(1<<SIZE)-1];
    logic [SIZE-1:0] log_addr [$];
    logic [31:0]     log_data [$];

    prog_loader #(.SIZE(SIZE)) dut (
        .clk       (clk),
        .rst       (rst),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .load_req  (load_req),
        .cpu_rst   (cpu_rst),
        .busy      (busy),
        .error     (error),
        .cpu_wrEn  (cpu_wrEn),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .ram_wrEn  (ram_wrEn),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sync-read RAM model plus write log.
    always @(posedge clk) begin
        if (ram_wrEn === 1'b1) begin
            mem[ram_addr] <= ram_wdata;
            log_addr.push_back(ram_addr);
            log_data.push_back(ram_wdata);
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Send one byte after 'gap' idle cycles; returns one tick after the
    // accepting edge. ld_valid drops afterwards unless the next call
    // raises it again in the same timestep.
    task automatic push(input logic [7:0] b, input int gap);
        logic got;
        got = 1'b0;
        ld_valid = 1'b0;
        repeat (gap) step();
        ld_valid = 1'b1;
        ld_data  = b;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ld_ready === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        if (!got) chk("push_ready_timeout", 32'(got), 32'd1);
    endtask

    task automatic reload();
        load_req = 1'b1;
        step();
        load_req = 1'b0;
    endtask

    int n0;
    logic [7:0] gbytes [12];

    initial begin
        rst = 1'b1; ld_valid = 1'b0; ld_data = '0; load_req = 1'b0;
        cpu_wrEn = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        gbytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                   8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
        repeat (3) step();
        rst = 1'b0;

        // ---- reset state ----
        chk("rst_cpu_rst",  32'(cpu_rst),  32'd1);
        chk("rst_wrEn",     32'(ram_wrEn), 32'd0);
        chk("rst_addr",     32'(ram_addr), 32'd0);
        chk("rst_wdata",    ram_wdata,     32'd0);
        chk("rst_error",    32'(error),    32'd0);
        chk("rst_busy",     32'(busy),     32'd1);
        chk("rst_ready",    32'(ld_ready), 32'd1);

        // ---- N=2 gapless ----
        push(8'h02, 0); push(8'h00, 0);
        push(8'h78, 0); push(8'h56, 0); push(8'h34, 0); push(8'h12, 0);
        chk("n2_w0_en",   32'(ram_wrEn), 32'd1);
        chk("n2_w0_addr", 32'(ram_addr), 32'd0);
        chk("n2_w0_data", ram_wdata,     32'h12345678);
        push(8'hEF, 0); push(8'hBE, 0); push(8'hAD, 0); push(8'hDE, 0);
        chk("n2_w1_en",    32'(ram_wrEn), 32'd1);
        chk("n2_w1_addr",  32'(ram_addr), 32'd1);
        chk("n2_w1_data",  ram_wdata,     32'hDEADBEEF);
        chk("n2_drain_rdy", 32'(ld_ready), 32'd0);
        chk("n2_drain_busy", 32'(busy),   32'd1);
        chk("n2_drain_cpurst", 32'(cpu_rst), 32'd1);
        step();
        chk("n2_run_cpurst", 32'(cpu_rst),  32'd0);
        chk("n2_run_busy",   32'(busy),     32'd0);
        chk("n2_run_ready",  32'(ld_ready), 32'd0);
        chk("n2_run_wrEn",   32'(ram_wrEn), 32'd0);
        chk("n2_nwrites",    32'(log_addr.size()), 32'd2);
        cpu_addr = 14'd1;
        step();
        chk("n2_rdata1", cpu_rdata, 32'hDEADBEEF);

        // ---- CPU write in RUN, then load_req ----
        cpu_wrEn = 1'b1; cpu_addr = 14'd5; cpu_wdata = 32'h000000AA;
        #1;
        chk("run_mux_en",   32'(ram_wrEn), 32'd1);
        chk("run_mux_addr", 32'(ram_addr), 32'd5);
        chk("run_mux_data", ram_wdata,     32'h000000AA);
        n0 = log_addr.size();
        load_req = 1'b1;
        #1;
        chk("lreq_drop_en", 32'(ram_wrEn), 32'd0);
        step();
        load_req = 1'b0;
        chk("lreq_cpurst", 32'(cpu_rst),  32'd1);
        chk("lreq_ready",  32'(ld_ready), 32'd1);
        chk("lreq_wrEn",   32'(ram_wrEn), 32'd0);
        push(8'h01, 0); push(8'h00, 0);
        push(8'h11, 0); push(8'h22, 0); push(8'h33, 0); push(8'h44, 0);
        chk("rl_w0_addr", 32'(ram_addr), 32'd0);
        chk("rl_w0_data", ram_wdata,     32'h44332211);
        step();
        chk("rl_cpurst",  32'(cpu_rst), 32'd0);
        chk("rl_nwrites", 32'(log_addr.size() - n0), 32'd1);
        cpu_wrEn = 1'b0;
        cpu_addr = 14'd0;
        step();
        chk("rl_rdata0", cpu_rdata, 32'h44332211);

        // ---- N=0 ----
        reload();
        n0 = log_addr.size();
        push(8'h00, 0); push(8'h00, 0);
        chk("n0_cpurst",  32'(cpu_rst), 32'd0);
        chk("n0_busy",    32'(busy),    32'd0);
        chk("n0_nwrites", 32'(log_addr.size() - n0), 32'd0);

        // ---- N=0x4001: error ----
        reload();
        push(8'h01, 0); push(8'h40, 0);
        chk("err_error",  32'(error),    32'd1);
        chk("err_ready",  32'(ld_ready), 32'd0);
        chk("err_cpurst", 32'(cpu_rst),  32'd1);
        ld_valid = 1'b1; ld_data = 8'h55;
        load_req = 1'b1;
        step();
        load_req = 1'b0;
        repeat (3) step();
        ld_valid = 1'b0;
        chk("err_hold",    32'(error), 32'd1);
        chk("err_nwrites", 32'(log_addr.size() - n0), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("err_rst_error", 32'(error),    32'd0);
        chk("err_rst_busy",  32'(busy),     32'd1);
        chk("err_rst_ready", 32'(ld_ready), 32'd1);
        chk("err_rst_wdata", ram_wdata,     32'd0);

        // ---- N=0x4000: legal boundary, enters DATA ----
        push(8'h00, 0); push(8'h40, 0);
        chk("max_error", 32'(error),    32'd0);
        chk("max_busy",  32'(busy),     32'd1);
        chk("max_ready", 32'(ld_ready), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;

        // ---- N=3 with random gaps ----
        n0 = log_addr.size();
        push(8'h03, int'($urandom_range(0, 3)));
        push(8'h00, int'($urandom_range(0, 3)));
        for (int i = 0; i < 12; i++) push(gbytes[i], int'($urandom_range(0, 3)));
        step();
        chk("gap_cpurst",  32'(cpu_rst), 32'd0);
        chk("gap_nwrites", 32'(log_addr.size() - n0), 32'd3);
        if (log_addr.size() >= n0 + 3) begin
            chk("gap_a0", 32'(log_addr[n0]),   32'd0);
            chk("gap_d0", log_data[n0],        32'h04030201);
            chk("gap_a1", 32'(log_addr[n0+1]), 32'd1);
            chk("gap_d1", log_data[n0+1],      32'h08070605);
            chk("gap_a2", 32'(log_addr[n0+2]), 32'd2);
            chk("gap_d2", log_data[n0+2],      32'h0C0B0A09);
        end

        // ---- rst mid-word ----
        reload();
        n0 = log_addr.size();
        push(8'h01, 0); push(8'h00, 0); push(8'hAA, 0); push(8'hBB, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_nwrites", 32'(log_addr.size() - n0), 32'd0);
        chk("mid_cpurst",  32'(cpu_rst), 32'd1);
        chk("mid_busy",    32'(busy),    32'd1);
        push(8'h01, 0); push(8'h00, 0);
        push(8'h55, 0); push(8'h66, 0); push(8'h77, 0); push(8'h88, 0);
        chk("mid_w_en",   32'(ram_wrEn), 32'd1);
        chk("mid_w_addr", 32'(ram_addr), 32'd0);
        chk("mid_w_data", ram_wdata,     32'h88776655);
        step();
        chk("mid_cpurst_rel", 32'(cpu_rst), 32'd0);
        chk("mid_nwrites2",   32'(log_addr.size() - n0), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time program loader between an external byte stream (UART receiver or testbench) and the single-port 32-bit RAM shared with the CPU.
- While loading, it owns the RAM port and holds the CPU in reset. It assembles little-endian bytes into 32-bit words and writes them from address 0 upward.
- When loading finishes, it releases the CPU reset and passes the RAM port through to the CPU unchanged.

Parameters:
SIZE, 14, RAM address width in bits (2**SIZE words).

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high; clock clk
ld_valid  in  1  byte-stream valid
ld_data  in  8  byte-stream data
ld_ready  out  1  byte-stream ready; a byte is transferred when ld_valid & ld_ready at a rising edge
load_req  in  1  single-cycle pulse that requests a reload; honoured only in RUN
cpu_rst  out  1  reset to the CPU; registered
cpu_wrEn  in  1  CPU write enable
cpu_addr  in  SIZE  CPU address
cpu_wdata  in  32  CPU write data
cpu_rdata  out  32  read data to the CPU; always equal to ram_rdata
ram_wrEn  out  1  RAM write enable
ram_addr  out  SIZE  RAM address
ram_wdata  out  32  RAM write data
ram_rdata  in  32  RAM read data; synchronous read, one-cycle latency
busy  out  1  1 in HDR0, HDR1 and DATA
error  out  1  1 in ERR

Behaviour:
- Stream format:
  - Byte 0 and byte 1 form a 16-bit word count N, low byte first.
  - Then 4*N payload bytes follow. Byte k of each word lands in bits [8k+7:8k].
- States:
  - HDR0: accept the N low byte, then go to HDR1.
  - HDR1: accept the N high byte. The next state is:
    - RUN if N==0;
    - ERR if N > 2**SIZE;
    - DATA otherwise.
  - DATA: accept payload bytes. The 2-bit byte counter wraps 3->0.
  - RUN: CPU owns the RAM.
  - ERR: terminal until rst.
- Reset (rst=1 at an edge):
  - State goes to HDR0 and all counters clear.
  - cpu_rst=1, ram_wrEn=0, ram_addr=0, ram_wdata=0, error=0.
  - rst has priority over every other event, including mid-load. Partially assembled words are discarded. Words already written stay in RAM.
- ld_ready:
  - Registered-free decode of state: 1 in HDR0, HDR1 and DATA; 0 in RUN, ERR and during the write-drain cycle after the final word.
  - The byte stream never stalls between words.
- Write timing:
  - The 4th byte of word i is accepted at edge T.
  - Cycle T+1 drives ram_wrEn=1, ram_addr=i, ram_wdata=<assembled word>. These are registered outputs from a word holding register separate from the assembly shift register.
  - Bytes of word i+1 may be accepted concurrently with that write.
- Completion:
  - The word index (SIZE bits) and the remaining count (SIZE+1 bits) update on each word.
  - After the final word's write cycle (T+1), the state is RUN at T+2 and cpu_rst=0 from T+2.
  - For N==0, cpu_rst falls the cycle after the HDR1 accept.
  - N==2**SIZE is legal; the last address is 2**SIZE-1 with no wrap.
- RAM mux:
  - In RUN, ram_wrEn/ram_addr/ram_wdata equal cpu_wrEn/cpu_addr/cpu_wdata, combinationally.
  - In every other state they come from the loader registers. ram_wrEn=0 except in write cycles.
- load_req:
  - In RUN: the next state is HDR0 and cpu_rst=1 from the next cycle. The loader takes the RAM port in that same cycle and any concurrent CPU write is dropped.
  - Ignored in all other states.
- Simultaneous events: ld_valid in RUN or ERR is ignored because ld_ready=0.

Decomposition:
- Shared package prog_loader_pkg:
  - state enum (HDR0, HDR1, DATA, RUN, ERR);
  - constants BYTES_PER_WORD=4 and HDR_BYTES=2.
- One sub-module, byte_to_word_asm: 8-to-32 assembler with byte counter and word_valid pulse. The top holds the FSM, counters and mux.

Test Plan:
- N=2, bytes 02 00 | 78 56 34 12 | EF BE AD DE with ld_valid held high:
  - writes 0x12345678 @0 and 0xDEADBEEF @1, each one cycle after its 4th byte;
  - cpu_rst falls 2 cycles after the last byte;
  - busy falls with it.
- N=0 (00 00): no RAM write; cpu_rst=0 one cycle after the second header byte.
- N=0x4001 with SIZE=14: error=1, ld_ready=0, cpu_rst stays 1, no writes. rst returns the block to HDR0.
- Gaps in ld_valid (random 0-3 idle cycles) with N=3: data and addresses are identical to the gapless case.
- In RUN with CPU writing 0xAA @5 continuously, pulse load_req:
  - cpu_rst=1 next cycle;
  - RAM mux switches to the loader and the CPU write is dropped;
  - a fresh load with N=1 writes @0 and releases.
- rst asserted after 2 payload bytes: no RAM write for the partial word; after rst a full N=1 load writes the new word @0.
